// File: rtl/dispatch_ctrl_pkg.sv
// Shared types and constants for the dispatch stage: field widths, op classes,
// opcodes, the held-instruction record and the dispatch FSM states.
package dispatch_ctrl_pkg;

  localparam int unsigned AddrWidth   = 32;
  localparam int unsigned OpTypeWidth = 3;
  localparam int unsigned OpWidth     = 7;
  localparam int unsigned RegWidth    = 5;
  localparam int unsigned DataWidth   = 32;

  typedef enum logic [OpTypeWidth-1:0] {
    OpNop    = 3'd0,
    OpArith  = 3'd1,
    OpLoad   = 3'd2,
    OpSave   = 3'd3,
    OpJump   = 3'd4,
    OpBranch = 3'd5
  } op_type_e;

  localparam logic [OpWidth-1:0] OpcAddi = 7'b0010011;
  localparam logic [OpWidth-1:0] OpcAdd  = 7'b0110011;
  localparam logic [OpWidth-1:0] OpcLw   = 7'b0000011;
  localparam logic [OpWidth-1:0] OpcSw   = 7'b0100011;
  localparam logic [OpWidth-1:0] OpcBeq  = 7'b1100011;
  localparam logic [OpWidth-1:0] OpcJal  = 7'b1101111;

  typedef enum logic {StIdle, StHold} state_e;

  typedef struct packed {
    logic [AddrWidth-1:0] pc;
    op_type_e             op_type;
    logic [OpWidth-1:0]   opcode;
    logic [RegWidth-1:0]  rs1;
    logic [RegWidth-1:0]  rs2;
    logic [RegWidth-1:0]  rd;
    logic [DataWidth-1:0] imm;
  } instr_t;

  // Memory ops go to the load/store buffer; everything else to the reservation station.
  function automatic logic is_lsb_op(op_type_e op);
    return (op == OpLoad) || (op == OpSave);
  endfunction

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Decoder-side and backend-side handshake bundle of the dispatch stage.
// The slave modport is the dispatch controller; master is its environment.
interface dispatch_ctrl_if
  import dispatch_ctrl_pkg::*;
#(
  parameter int unsigned ROB_TAG_WIDTH = 4
);

  logic                     rdy_dec_in;
  logic [AddrWidth-1:0]     pc_dec_in;
  logic [OpTypeWidth-1:0]   op_type_dec_in;
  logic [OpWidth-1:0]       opcode_dec_in;
  logic [RegWidth-1:0]      rs1_dec_in;
  logic [RegWidth-1:0]      rs2_dec_in;
  logic [RegWidth-1:0]      rd_dec_in;
  logic [DataWidth-1:0]     imm_dec_in;
  logic                     rdy_dispatch_dec_out;

  logic                     rob_full_in;
  logic                     rs_full_in;
  logic                     lsb_full_in;
  logic [ROB_TAG_WIDTH-1:0] rob_tag_in;

  logic                     rob_alloc_out;
  logic                     rs_issue_out;
  logic                     lsb_issue_out;
  logic [AddrWidth-1:0]     pc_out;
  logic [OpTypeWidth-1:0]   op_type_out;
  logic [OpWidth-1:0]       opcode_out;
  logic [RegWidth-1:0]      rs1_out;
  logic [RegWidth-1:0]      rs2_out;
  logic [RegWidth-1:0]      rd_out;
  logic [DataWidth-1:0]     imm_out;
  logic [ROB_TAG_WIDTH-1:0] tag_out;

  modport slave (
    input  rdy_dec_in, pc_dec_in, op_type_dec_in, opcode_dec_in, rs1_dec_in, rs2_dec_in,
           rd_dec_in, imm_dec_in, rob_full_in, rs_full_in, lsb_full_in, rob_tag_in,
    output rdy_dispatch_dec_out, rob_alloc_out, rs_issue_out, lsb_issue_out, pc_out,
           op_type_out, opcode_out, rs1_out, rs2_out, rd_out, imm_out, tag_out
  );

  modport master (
    output rdy_dec_in, pc_dec_in, op_type_dec_in, opcode_dec_in, rs1_dec_in, rs2_dec_in,
           rd_dec_in, imm_dec_in, rob_full_in, rs_full_in, lsb_full_in, rob_tag_in,
    input  rdy_dispatch_dec_out, rob_alloc_out, rs_issue_out, lsb_issue_out, pc_out,
           op_type_out, opcode_out, rs1_out, rs2_out, rd_out, imm_out, tag_out
  );

endinterface

// File: rtl/dispatch_ctrl.sv
// Single-entry dispatch buffer between decoder and ROB/RS/LSB, one issue per cycle.
// Define DISPATCH_STALL_CNT_EN to build the stall-cycle counter on stall_cnt_out.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int unsigned ROB_TAG_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 clear_in,
  dispatch_ctrl_if.slave       bus,
  output logic [31:0]          stall_cnt_out
);

  state_e                   state_q, state_d;
  instr_t                   hold_q;
  instr_t                   dec_instr;
  logic [ROB_TAG_WIDTH-1:0] tag;
  logic                     in_hold;
  logic                     to_lsb;
  logic                     target_full;
  logic                     issue_now;
  logic                     accept;
  logic                     load;

  assign dec_instr = '{
    pc:      bus.pc_dec_in,
    op_type: op_type_e'(bus.op_type_dec_in),
    opcode:  bus.opcode_dec_in,
    rs1:     bus.rs1_dec_in,
    rs2:     bus.rs2_dec_in,
    rd:      bus.rd_dec_in,
    imm:     bus.imm_dec_in
  };

  assign tag         = bus.rob_tag_in;
  assign in_hold     = (state_q == StHold);
  assign to_lsb      = is_lsb_op(hold_q.op_type);
  assign target_full = to_lsb ? bus.lsb_full_in : bus.rs_full_in;
  // Reset gates the handshakes combinationally so they drop the moment rst_n_in falls.
  assign issue_now   = rst_n_in & in_hold & rdy_in & ~clear_in & ~bus.rob_full_in & ~target_full;
  assign accept      = rst_n_in & rdy_in & ~clear_in & bus.rdy_dec_in & (~in_hold | issue_now);
  assign load        = accept & (dec_instr.op_type != OpNop);

  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      if (clear_in) begin
        state_d = StIdle;
      end else if (load) begin
        state_d = StHold;
      end else if (issue_now) begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        hold_q <= dec_instr;
      end
    end
  end

  always_comb begin
    bus.rdy_dispatch_dec_out = accept;
    bus.rob_alloc_out        = issue_now;
    bus.rs_issue_out         = issue_now & ~to_lsb;
    bus.lsb_issue_out        = issue_now & to_lsb;
    bus.tag_out              = '0;
    bus.pc_out               = '0;
    bus.op_type_out          = '0;
    bus.opcode_out           = '0;
    bus.rs1_out              = '0;
    bus.rs2_out              = '0;
    bus.rd_out               = '0;
    bus.imm_out              = '0;
    if (issue_now) begin
      bus.tag_out = tag;
    end
    if (in_hold) begin
      bus.pc_out      = hold_q.pc;
      bus.op_type_out = hold_q.op_type;
      bus.opcode_out  = hold_q.opcode;
      bus.rs1_out     = hold_q.rs1;
      bus.rs2_out     = hold_q.rs2;
      bus.rd_out      = hold_q.rd;
      bus.imm_out     = hold_q.imm;
    end
  end

`ifdef DISPATCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Counts cycles a held instruction was blocked by a full resource; clear does not reset it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stall_cnt_q <= '0;
    end else if (in_hold && rdy_in && !clear_in && !issue_now) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
`else
  assign stall_cnt_out = '0;
`endif

endmodule
